prog_timer: RTL and testbench
=============================

Name: prog_timer

Overview:
- Multi-channel programmable countdown timer for pacing, debounce and timeout logic.
- NCH independent channels share one free-running prescaler.
- Each channel is started with a run-time load value.
- Each channel runs one-shot or periodic, can be paused, stopped or restarted, and emits a one-cycle expire pulse per period.

Parameters:
- NCH, 4: number of independent channels (>=1).
- CW, 16: counter/load-value width per channel (>=2).
- PRESCALE, 1: clk cycles per count tick (>=1); 1 means every cycle is a tick.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- start  in  NCH  per-channel start/restart request, sampled each edge.
- stop  in  NCH  per-channel abort request.
- pause  in  NCH  per-channel level; while high the channel holds its count.
- mode  in  NCH  per-channel mode at start: 0 one-shot, 1 periodic.
- load_val  in  NCH*CW  per-channel period in ticks; channel i at bits [i*CW +: CW].
- busy  out  NCH  channel i is in RUN.
- expire  out  NCH  one-cycle pulse per completed period.
- count  out  NCH*CW  current remaining count per channel, same packing as load_val.

Behaviour:
- Reset (async): prescaler=0; every channel IDLE; busy=0, expire=0, count=0; latched mode/period=0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - tick=1 in the cycle the prescaler equals PRESCALE-1; tick is always 1 when PRESCALE=1.
  - Free-running, never reset by start/stop/pause.
- Channel states: IDLE, RUN. Per-edge priority: stop > start > tick.
- stop:
  - Any state -> IDLE; count=0; no expire.
  - Overrides a simultaneous start or terminal tick.
- start, with load_val L:
  - L!=0: latch mode and L; count=L-1; -> RUN.
  - Allowed from IDLE or RUN; a start in RUN is a restart and produces no expire for the aborted period.
  - L==0: start ignored, state unchanged.
- RUN, tick=1, pause=0:
  - count!=0: count decrements by 1.
  - count==0: expire=1 for the next cycle (registered). One-shot -> IDLE, count stays 0. Periodic -> count=latched L-1, stays RUN.
- RUN, pause=1: count and state hold; a terminal tick while paused is skipped (no expire). Resume continues from the held count.
- IDLE: ticks and pause have no effect.
- Latency with PRESCALE=1:
  - Start sampled at edge e, so expire is high in the cycle after edge e+L.
  - Periodic expires repeat every L cycles.
- Latency with PRESCALE>1: the first period is L ticks, and the first tick may arrive 1..PRESCALE cycles after start (phase uncertainty is allowed).
- busy tracks state (RUN=1) registered, updated on the same edge as the state change.
- Wrap-around: count never underflows; the reload path is the only transition out of 0 while in RUN. L=2^CW-1 is supported.
- Channels are fully independent. Simultaneous events on different channels are all honoured on the same edge.

Decomposition:
- Package prog_timer_pkg:
  - typedef enum logic {IDLE, RUN} tstate_t;
  - typedef enum logic {ONESHOT=0, PERIODIC=1} tmode_t;
  - A function returning the prescaler width, $clog2(PRESCALE) clamped to >=1.
- Sub-module timer_channel (parameter CW):
  - Inputs: clk, rst, tick, start, stop, pause, mode, load_val.
  - Outputs: busy, expire, count.
- prog_timer holds the shared prescaler and a generate loop of NCH timer_channel instances.

Test Plan:
- NCH=4, PRESCALE=1, ch0 one-shot, L=5, start at edge 10 -> count 4,3,2,1,0 on edges 10..14; expire high only in the cycle after edge 15; busy 1 on edges 10..14, 0 from edge 15.
- ch1 periodic, L=3, PRESCALE=1 -> expire pulses every 3 cycles, 10 consecutive periods; count sequence 2,1,0,2,1,0...; busy stays 1.
- ch2 one-shot, L=8, PRESCALE=4 -> count decrements only on tick cycles, every 4 clk; expire after 8 ticks (29..32 cycles after start); pause held 3 ticks mid-run extends it by exactly 3 ticks.
- ch0 running L=6: restart with L=2 at count=3 -> no expire for the old period; expire 2 edges after the restart. Same-edge start+stop -> IDLE, count 0, no expire.
- Terminal-tick corners:
  - stop on the edge where count==0 -> no expire.
  - pause high at count==0 for 2 ticks, then released -> expire on the first unpaused tick.
  - start with L=0 -> ignored (busy stays 0).
- rst asserted asynchronously mid-run on all channels (not on a clk edge) -> busy, expire, count go to 0 immediately. After release, a fresh start with L=4 behaves exactly as the first test.

Source files
------------

// File: rtl/prog_timer_pkg.sv
// Shared types and helpers for the multi-channel programmable countdown timer.
package prog_timer_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} tstate_t;
  typedef enum logic {ONESHOT = 1'b0, PERIODIC = 1'b1} tmode_t;

  // Prescaler register width; a one-bit counter is the floor even when PRESCALE <= 2.
  function automatic int presc_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: start/restart, stop, pause, one-shot or periodic reload.
// Edge priority is stop > start > tick; expire is a registered one-cycle pulse.
module timer_channel
  import prog_timer_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          mode,
  input  logic [CW-1:0] load_val,
  output logic          busy,
  output logic          expire,
  output logic [CW-1:0] count
);

  tstate_t       state, state_nxt;
  tmode_t        mode_q, mode_nxt;
  logic [CW-1:0] period_q, period_nxt;
  logic [CW-1:0] count_nxt;
  logic          expire_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mode_q   <= ONESHOT;
      period_q <= '0;
      count    <= '0;
      expire   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode_q   <= mode_nxt;
      period_q <= period_nxt;
      count    <= count_nxt;
      expire   <= expire_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mode_nxt   = mode_q;
    period_nxt = period_q;
    count_nxt  = count;
    expire_nxt = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      count_nxt = '0;
    end else if (start && (load_val != '0)) begin
      state_nxt  = RUN;
      mode_nxt   = tmode_t'(mode);
      period_nxt = load_val;
      count_nxt  = load_val - CW'(1);
    end else if ((state == RUN) && tick && !pause) begin
      if (count != '0) begin
        count_nxt = count - CW'(1);
      end else begin
        // Terminal tick: reload is the only way out of zero while running.
        expire_nxt = 1'b1;
        if (mode_q == PERIODIC) count_nxt = period_q - CW'(1);
        else                    state_nxt = IDLE;
      end
    end
  end

  // busy is the externally visible view of the channel state register.
  assign busy = (state == RUN);

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable countdown timer: one free-running prescaler
// shared by NCH independent timer_channel instances.
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int CW       = 16,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    pause,
  input  logic [NCH-1:0]    mode,
  input  logic [NCH*CW-1:0] load_val,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    expire,
  output logic [NCH*CW-1:0] count
);

  logic tick;

  generate
    if (PRESCALE == 1) begin : g_no_presc
      assign tick = 1'b1;
    end else begin : g_presc
      localparam int PW = presc_width(PRESCALE);
      logic [PW-1:0] presc;

      // Never touched by channel controls, so tick phase is global.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                             presc <= '0;
        else if (presc == PW'(PRESCALE - 1)) presc <= '0;
        else                                 presc <= presc + PW'(1);
      end

      assign tick = (presc == PW'(PRESCALE - 1));
    end
  endgenerate

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      timer_channel #(.CW(CW)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .start    (start[i]),
        .stop     (stop[i]),
        .pause    (pause[i]),
        .mode     (mode[i]),
        .load_val (load_val[i*CW +: CW]),
        .busy     (busy[i]),
        .expire   (expire[i]),
        .count    (count[i*CW +: CW])
      );
    end
  endgenerate

endmodule

// File: tb/tb_prog_timer.sv
// Bench for prog_timer: a PRESCALE=1 and a PRESCALE=4 instance, directed
// scenarios plus random traffic, all compared against an elapsed-tick model.
module tb_prog_timer;
  localparam int NCH = 4;
  localparam int CW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NCH-1:0]    start_i [2];
  logic [NCH-1:0]    stop_i  [2];
  logic [NCH-1:0]    pause_i [2];
  logic [NCH-1:0]    mode_i  [2];
  logic [NCH*CW-1:0] load_i  [2];
  logic [NCH-1:0]    busy_o  [2];
  logic [NCH-1:0]    expire_o[2];
  logic [NCH*CW-1:0] count_o [2];

  int checks = 0;
  int errors = 0;

  // Model: each running channel tracks ticks elapsed within its current period.
  int edge_k;
  bit m_run[2][NCH];
  bit m_per[2][NCH];
  bit m_exp[2][NCH];
  int m_len[2][NCH];
  int m_el [2][NCH];

  always #5 clk = ~clk;

  prog_timer #(.NCH(NCH), .CW(CW), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_i[0]), .stop(stop_i[0]), .pause(pause_i[0]),
    .mode(mode_i[0]), .load_val(load_i[0]), .busy(busy_o[0]), .expire(expire_o[0]),
    .count(count_o[0])
  );

  prog_timer #(.NCH(NCH), .CW(CW), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_i[1]), .stop(stop_i[1]), .pause(pause_i[1]),
    .mode(mode_i[1]), .load_val(load_i[1]), .busy(busy_o[1]), .expire(expire_o[1]),
    .count(count_o[1])
  );

  function automatic int ps(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic int m_count(input int d, input int c);
    return m_run[d][c] ? (m_len[d][c] - 1 - m_el[d][c]) : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    edge_k = 0;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_run[d][c] = 0; m_per[d][c] = 0; m_exp[d][c] = 0;
        m_len[d][c] = 0; m_el[d][c]  = 0;
      end
  endtask

  task automatic model_edge();
    bit tk;
    int l;
    for (int d = 0; d < 2; d++) begin
      tk = ((edge_k % ps(d)) == ps(d) - 1);
      for (int c = 0; c < NCH; c++) begin
        l = int'(load_i[d][c*CW +: CW]);
        m_exp[d][c] = 0;
        if (stop_i[d][c]) begin
          m_run[d][c] = 0;
          m_el[d][c]  = 0;
        end else if (start_i[d][c] && l != 0) begin
          m_run[d][c] = 1;
          m_per[d][c] = mode_i[d][c];
          m_len[d][c] = l;
          m_el[d][c]  = 0;
        end else if (m_run[d][c] && tk && !pause_i[d][c]) begin
          if (m_el[d][c] == m_len[d][c] - 1) begin
            m_exp[d][c] = 1;
            m_el[d][c]  = 0;
            if (!m_per[d][c]) m_run[d][c] = 0;
          end else begin
            m_el[d][c]++;
          end
        end
      end
    end
    edge_k++;
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("busy d%0d c%0d", d, c), 32'(busy_o[d][c]), 32'(m_run[d][c]));
        chk($sformatf("expire d%0d c%0d", d, c), 32'(expire_o[d][c]), 32'(m_exp[d][c]));
        chk($sformatf("count d%0d c%0d", d, c), 32'(count_o[d][c*CW +: CW]), 32'(m_count(d, c)));
      end
  endtask

  task automatic step(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      model_edge();
      #1 check_all();
    end
  endtask

  task automatic pulse_start(input int d, input int c, input int l, input bit md);
    load_i[d][c*CW +: CW] = l[CW-1:0];
    mode_i[d][c]  = md;
    start_i[d][c] = 1'b1;
    step(1);
    start_i[d][c] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s busy d%0d", tag, d), 32'(busy_o[d]), 32'd0);
      chk($sformatf("%s expire d%0d", tag, d), 32'(expire_o[d]), 32'd0);
      chk($sformatf("%s count d%0d", tag, d), count_o[d][31:0], 32'd0);
      chk($sformatf("%s count_hi d%0d", tag, d), count_o[d][63:32], 32'd0);
    end
  endtask

  initial begin
    int n;
    int ne;
    int r;
    for (int d = 0; d < 2; d++) begin
      start_i[d] = '0; stop_i[d] = '0; pause_i[d] = '0; mode_i[d] = '0; load_i[d] = '0;
    end
    model_reset();
    #12 check_zero("reset");
    @(negedge clk) rst = 1'b0;

    // One-shot L=5 on ch0 of the unprescaled instance.
    step(9);
    pulse_start(0, 0, 5, 1'b0);
    chk("t1 count0", 32'(count_o[0][15:0]), 32'd4);
    chk("t1 busy0", 32'(busy_o[0][0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("t1 count", 32'(count_o[0][15:0]), 32'(4 - k));
      chk("t1 busy", 32'(busy_o[0][0]), 32'd1);
      chk("t1 no expire", 32'(expire_o[0][0]), 32'd0);
    end
    step(1);
    chk("t1 expire", 32'(expire_o[0][0]), 32'd1);
    chk("t1 busy end", 32'(busy_o[0][0]), 32'd0);
    step(1);
    chk("t1 expire drop", 32'(expire_o[0][0]), 32'd0);

    // Periodic L=3 on ch1: ten consecutive periods.
    pulse_start(0, 1, 3, 1'b1);
    chk("t2 count0", 32'(count_o[0][31:16]), 32'd2);
    ne = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      chk("t2 count", 32'(count_o[0][31:16]), 32'(2 - (k % 3)));
      chk("t2 expire", 32'(expire_o[0][1]), 32'((k % 3) == 0));
      chk("t2 busy", 32'(busy_o[0][1]), 32'd1);
      if (expire_o[0][1]) ne++;
    end
    chk("t2 periods", 32'(ne), 32'd10);
    stop_i[0][1] = 1'b1; step(1); stop_i[0][1] = 1'b0;

    // Prescaled one-shot L=8 on ch2, without and with a 3-tick pause.
    pulse_start(1, 2, 8, 1'b0);
    n = 0;
    while (n < 60 && !expire_o[1][2]) begin step(1); n++; end
    chk("t3 latency in 29..32", 32'(n >= 29 && n <= 32), 32'd1);
    step(2);
    pulse_start(1, 2, 8, 1'b0);
    step(8);
    pause_i[1][2] = 1'b1; step(12); pause_i[1][2] = 1'b0;
    n = 20;
    while (n < 80 && !expire_o[1][2]) begin step(1); n++; end
    chk("t3 paused latency in 41..44", 32'(n >= 41 && n <= 44), 32'd1);

    // Restart mid-period, then start and stop on the same edge.
    pulse_start(0, 0, 6, 1'b0);
    step(2);
    chk("t4 count before restart", 32'(count_o[0][15:0]), 32'd3);
    pulse_start(0, 0, 2, 1'b0);
    chk("t4 restart count", 32'(count_o[0][15:0]), 32'd1);
    chk("t4 restart no expire", 32'(expire_o[0][0]), 32'd0);
    step(1);
    chk("t4 no expire r+1", 32'(expire_o[0][0]), 32'd0);
    step(1);
    chk("t4 expire r+2", 32'(expire_o[0][0]), 32'd1);
    load_i[0][15:0] = 16'd5; start_i[0][0] = 1'b1; stop_i[0][0] = 1'b1;
    step(1);
    start_i[0][0] = 1'b0; stop_i[0][0] = 1'b0;
    chk("t4 start+stop busy", 32'(busy_o[0][0]), 32'd0);
    chk("t4 start+stop count", 32'(count_o[0][15:0]), 32'd0);
    step(1);
    chk("t4 start+stop no expire", 32'(expire_o[0][0]), 32'd0);

    // Terminal-tick corners.
    pulse_start(0, 0, 3, 1'b0);
    step(2);
    stop_i[0][0] = 1'b1; step(1); stop_i[0][0] = 1'b0;
    chk("t5 stop at zero busy", 32'(busy_o[0][0]), 32'd0);
    chk("t5 stop at zero expire", 32'(expire_o[0][0]), 32'd0);
    step(1);
    chk("t5 stop at zero late expire", 32'(expire_o[0][0]), 32'd0);
    pulse_start(0, 0, 2, 1'b0);
    step(1);
    pause_i[0][0] = 1'b1; step(2);
    chk("t5 paused at zero expire", 32'(expire_o[0][0]), 32'd0);
    chk("t5 paused at zero busy", 32'(busy_o[0][0]), 32'd1);
    pause_i[0][0] = 1'b0; step(1);
    chk("t5 resume expire", 32'(expire_o[0][0]), 32'd1);
    chk("t5 resume busy", 32'(busy_o[0][0]), 32'd0);
    pulse_start(0, 3, 0, 1'b0);
    chk("t5 zero load busy", 32'(busy_o[0][3]), 32'd0);

    // Asynchronous reset mid-run, then a fresh L=4 start.
    for (int d = 0; d < 2; d++) begin
      start_i[d] = '1;
      for (int c = 0; c < NCH; c++) load_i[d][c*CW +: CW] = 16'd20;
    end
    step(1);
    start_i[0] = '0; start_i[1] = '0;
    step(5);
    #2 rst = 1'b1;
    #1 check_zero("async reset");
    model_reset();
    @(negedge clk) rst = 1'b0;
    pulse_start(0, 0, 4, 1'b0);
    chk("t6 count0", 32'(count_o[0][15:0]), 32'd3);
    step(3);
    chk("t6 count end", 32'(count_o[0][15:0]), 32'd0);
    step(1);
    chk("t6 expire", 32'(expire_o[0][0]), 32'd1);

    // Random traffic on every channel of both instances.
    for (int it = 0; it < 400; it++) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NCH; c++) begin
          start_i[d][c] = ($urandom_range(0, 11) == 0);
          stop_i[d][c]  = ($urandom_range(0, 39) == 0);
          pause_i[d][c] = ($urandom_range(0, 7) == 0);
          mode_i[d][c]  = 1'($urandom_range(0, 1));
          r = int'($urandom_range(0, 19));
          if (r == 0)      load_i[d][c*CW +: CW] = 16'd0;
          else if (r == 1) load_i[d][c*CW +: CW] = 16'hFFFF;
          else             load_i[d][c*CW +: CW] = 16'($urandom_range(1, 12));
        end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
